// File: rtl/seq_stimulus_ctrl_pkg.sv
// Shared types and constants for the serial stimulus controller.
// Optional loop playback is selected with the SEQ_LOOP_EN macro (see seq_stimulus_ctrl.sv).
package seq_stimulus_ctrl_pkg;

    localparam int PAT_W = 16;
    localparam int LEN_W = 5;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LOAD  = 4'd1,
        S_RUN   = 4'd2,
        S_DRAIN = 4'd3,
        S_DONE  = 4'd4
    } state_t;

    // A len of 0, or any len longer than the pattern, plays the whole pattern
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
        return (l == '0 || l > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : l;
    endfunction

endpackage

// File: rtl/seq_stimulus_ctrl_tick_div.sv
// Step-rate divider: tick fires on every TICK_DIV-th enabled cycle, counting from a clear.
module tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/seq_stimulus_ctrl.sv
// Plays a latched pattern MSB first into a sequence detector and counts its detections.
// Define SEQ_LOOP_EN to replay the pattern indefinitely instead of finishing after len bits.
module seq_stimulus_ctrl
    import seq_stimulus_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      pattern,
    input  logic [4:0]       len,
    input  logic             z_in,
    output logic             w,
    output logic             step,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic [3:0]       state_code
);

`ifdef SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    state_t           state, nxt;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx;
    logic [3:0]       bsel;
    logic             w_q;
    logic             step_d;
    logic             tick;
    logic             div_en;
    logic             last;
    logic             bit_cur;

    assign div_en = (state == S_RUN);

    tick_div #(.TICK_DIV(TICK_DIV)) u_div (
        .clk   (Clock),
        .rst_n (Resetn),
        .clr   (!div_en),
        .en    (div_en),
        .tick  (tick)
    );

    assign step    = tick;
    assign last    = step && (idx == len_q - 1'b1);
    assign bsel    = 4'(LEN_W'(PAT_W - 1) - idx);
    assign bit_cur = pat_q[bsel];

    // w is live in a step cycle and otherwise replays the last bit sent
    assign w          = (state == S_IDLE) ? 1'b0 : (step ? bit_cur : w_q);
    assign busy       = (state == S_LOAD) || (state == S_RUN) || (state == S_DRAIN);
    assign done       = (state == S_DONE);
    assign state_code = state;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start && !abort) nxt = S_LOAD;
            S_LOAD:  nxt = S_RUN;
            S_RUN:   if (last) nxt = LOOP ? S_RUN : S_DRAIN;
            S_DRAIN: nxt = S_DONE;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (state != S_IDLE && abort)
            nxt = S_IDLE;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pat_q  <= '0;
            len_q  <= '0;
            idx    <= '0;
            w_q    <= 1'b0;
            step_d <= 1'b0;
        end else begin
            step_d <= step;
            if (state == S_LOAD) begin
                idx <= '0;
                w_q <= 1'b0;
            end else if (step) begin
                idx <= last ? '0 : idx + 1'b1;
                w_q <= bit_cur;
            end
            if (state == S_IDLE && start && !abort) begin
                pat_q <= pattern;
                len_q <= eff_len(len);
            end
        end
    end

    // Detector output is judged one cycle after each step, saturating
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            match_count <= '0;
        else if (state == S_LOAD)
            match_count <= '0;
        else if (step_d && z_in && (state == S_RUN || state == S_DRAIN) && match_count != '1)
            match_count <= match_count + 1'b1;
    end

endmodule

// File: tb/tb_seq_stimulus_ctrl.sv
// Directed bench for seq_stimulus_ctrl: playback, counting, length, abort, reset, saturation, loop.
module tb_seq_stimulus_ctrl;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        start, abort, z_in;
    logic [15:0] pattern;
    logic [4:0]  len;

    logic       w_a, step_a, busy_a, done_a;
    logic [7:0] mc_a;
    logic [3:0] st_a;
    logic       w_b, step_b, busy_b, done_b;
    logic [1:0] mc_b;
    logic [3:0] st_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 Clock = ~Clock;

    seq_stimulus_ctrl #(.TICK_DIV(4), .CNT_W(8)) dut_a (
        .Clock(Clock), .Resetn(Resetn), .start(start), .abort(abort),
        .pattern(pattern), .len(len), .z_in(z_in),
        .w(w_a), .step(step_a), .busy(busy_a), .done(done_a),
        .match_count(mc_a), .state_code(st_a)
    );

    seq_stimulus_ctrl #(.TICK_DIV(1), .CNT_W(2)) dut_b (
        .Clock(Clock), .Resetn(Resetn), .start(start), .abort(abort),
        .pattern(pattern), .len(len), .z_in(z_in),
        .w(w_b), .step(step_b), .busy(busy_b), .done(done_b),
        .match_count(mc_b), .state_code(st_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Leaves time just after a rising edge: the start of "cycle 0"
    task automatic do_reset();
        Resetn = 1'b0; start = 1'b0; abort = 1'b0; z_in = 1'b0;
        pattern = 16'h0; len = 5'd0;
        repeat (2) @(posedge Clock);
        #1 Resetn = 1'b1;
    endtask

    logic [3:0]  exp_st;
    logic [15:0] wbits;
    int          nst, first_st, last_st, done_cyc;
    logic        any_done;

    initial begin
        do_reset();
        @(negedge Clock);
        check("reset_state", {st_a, w_a, step_a, busy_a, done_a, mc_a}, 16'h0);
        @(posedge Clock); #1;

`ifndef SEQ_LOOP_EN
        // Basic playback with match counting; restart and pattern change mid-run must be ignored
        do_reset();
        pattern = 16'hB000; len = 5'd4;
        for (int c = 0; c < 26; c++) begin
            start = (c == 0 || c == 7);
            z_in  = (c == 10 || c == 18);
            if (c == 3) begin pattern = 16'h0; len = 5'd1; end
            @(negedge Clock);
            exp_st = (c == 0) ? 4'd0 : (c == 1) ? 4'd1 : (c <= 17) ? 4'd2 :
                     (c == 18) ? 4'd3 : (c == 19) ? 4'd4 : 4'd0;
            check($sformatf("basic_c%0d", c), {st_a, step_a, w_a, busy_a, done_a},
                  {exp_st, 1'(c == 5 || c == 9 || c == 13 || c == 17),
                   1'((c >= 5 && c < 9) || (c >= 13 && c < 20)),
                   1'(exp_st >= 4'd1 && exp_st <= 4'd3), 1'(c == 19)});
            if (c == 20 || c == 25) check($sformatf("match_c%0d", c), mc_a, 8'd2);
            @(posedge Clock); #1;
        end

        // len=0 then len=20 on the divide-by-1 instance; second run also saturates the 2-bit count
        for (int r = 0; r < 2; r++) begin
            do_reset();
            pattern = 16'hA5A5; len = (r == 0) ? 5'd0 : 5'd20;
            z_in = (r == 1);
            nst = 0; first_st = -1; last_st = -1; done_cyc = -1; wbits = 16'h0;
            for (int c = 0; c < 25; c++) begin
                start = (c == 0);
                @(negedge Clock);
                if (step_b) begin
                    nst++;
                    if (first_st < 0) first_st = c;
                    last_st = c;
                    wbits = {wbits[14:0], w_b};
                end
                if (done_b) done_cyc = c;
                @(posedge Clock); #1;
            end
            check($sformatf("len%0d_steps", r), nst, 16);
            check($sformatf("len%0d_first", r), first_st, 2);
            check($sformatf("len%0d_last", r), last_st, 17);
            check($sformatf("len%0d_done", r), done_cyc, 19);
            check($sformatf("len%0d_wbits", r), wbits, 16'hA5A5);
            check($sformatf("len%0d_count", r), mc_b, (r == 0) ? 2'd0 : 2'd3);
        end
`endif

        // Abort in cycle 10: one match already counted at cycle 6 must survive
        do_reset();
        pattern = 16'hB000; len = 5'd4;
        nst = 0; any_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            start = (c == 0);
            z_in  = (c == 6);
            abort = (c == 10);
            @(negedge Clock);
            if (step_a) nst++;
            if (done_a) any_done = 1'b1;
            if (c == 11) check("abort_idle", {st_a, busy_a, w_a}, 6'h0);
            @(posedge Clock); #1;
        end
        check("abort_steps", nst, 2);
        check("abort_nodone", any_done, 1'b0);
        check("abort_count", mc_a, 8'd1);

        // Asynchronous reset between edges in a step cycle
        do_reset();
        pattern = 16'hB000; len = 5'd4;
        for (int c = 0; c < 5; c++) begin
            start = (c == 0);
            @(posedge Clock); #1;
        end
        @(negedge Clock);
        check("pre_reset_step", {st_a, step_a, w_a}, 6'b0010_1_1);
        #1 Resetn = 1'b0;
        #1;
        check("async_reset", {st_a, w_a, step_a, busy_a, done_a, mc_a}, 16'h0);
        @(posedge Clock); #1 Resetn = 1'b1;
        start = 1'b1; abort = 1'b1;
        @(posedge Clock); #1 start = 1'b0; abort = 1'b0;
        @(negedge Clock);
        check("start_abort_idle", {st_a, busy_a}, 5'h0);

`ifdef SEQ_LOOP_EN
        // Loop mode: two-bit pattern repeats indefinitely, never finishing
        do_reset();
        pattern = 16'h8000; len = 5'd2;
        nst = 0; any_done = 1'b0; wbits = 16'h0;
        for (int c = 0; c < 40; c++) begin
            start = (c == 0);
            @(negedge Clock);
            if (step_a) begin nst++; wbits = {wbits[14:0], w_a}; end
            if (done_a) any_done = 1'b1;
            @(posedge Clock); #1;
        end
        check("loop_steps", nst, 9);
        check("loop_wbits", wbits[8:0], 9'b101010101);
        check("loop_nodone", any_done, 1'b0);
        check("loop_state", st_a, 4'd2);
        abort = 1'b1;
        @(posedge Clock); #1 abort = 1'b0;
        @(negedge Clock);
        check("loop_abort", st_a, 4'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
